// File: rtl/vx_csa_resolve.sv
// Multi-cycle carry-save to binary resolver: one CHUNK-bit carry-propagate step per cycle.
// Optional early exit when no carry can reach the upper chunks: define CSA_RESOLVE_EARLY_EXIT_EN.
module vx_csa_resolve #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [W-1:0] sum_in,
    input  logic [W-1:0] carry_in,
    input  logic         cin,
    output logic         valid_out,
    input  logic         ready_out,
    output logic [W-1:0] data_out,
    output logic         cout
);

    localparam int NSTEPS = (W + CHUNK - 1) / CHUNK;
    localparam int PW     = NSTEPS * CHUNK;
    localparam int LAST_W = W - (NSTEPS - 1) * CHUNK;
    localparam int IDX_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     sum_q, sum_d, carry_q, carry_d, res_q, res_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             c_q, c_d, cout_q, cout_d;

    logic [PW-1:0]    sum_pad, carry_pad, res_pad, chunk_mask;
    logic [W-1:0]     res_step;
    logic [31:0]      lo_bit;
    logic [CHUNK-1:0] chunk_s, chunk_c;
    logic [CHUNK:0]   chunk_sum;
    logic             last_step, step_carry;
`ifdef CSA_RESOLVE_EARLY_EXIT_EN
    logic [31:0]      hi_bit;
    logic [W-1:0]     hi_mask, res_early;
    logic             early;
`endif

    // Operands are zero-padded to a whole number of chunks so the last chunk
    // needs no special slicing; its carry is taken at bit LAST_W instead.
    always_comb begin
        sum_pad            = '0;
        sum_pad[W-1:0]     = sum_q;
        carry_pad          = '0;
        carry_pad[W-1:0]   = carry_q;
        res_pad            = '0;
        res_pad[W-1:0]     = res_q;
        lo_bit             = 32'(idx_q) * 32'(CHUNK);
        chunk_s            = CHUNK'(sum_pad >> lo_bit);
        chunk_c            = CHUNK'(carry_pad >> lo_bit);
        chunk_sum          = {1'b0, chunk_s} + {1'b0, chunk_c} + {{CHUNK{1'b0}}, c_q};
        chunk_mask         = PW'({CHUNK{1'b1}});
        res_step           = W'((res_pad & ~(chunk_mask << lo_bit))
                                | (PW'(chunk_sum[CHUNK-1:0]) << lo_bit));
        last_step          = (idx_q == IDX_W'(NSTEPS - 1));
        step_carry         = last_step ? chunk_sum[LAST_W] : chunk_sum[CHUNK];
`ifdef CSA_RESOLVE_EARLY_EXIT_EN
        hi_bit             = lo_bit + 32'(CHUNK);
        hi_mask            = {W{1'b1}} << hi_bit;
        res_early          = (res_step & ~hi_mask) | (sum_q & hi_mask);
        early              = !last_step && !chunk_sum[CHUNK] && ((carry_pad >> hi_bit) == '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        res_d   = res_q;
        idx_d   = idx_q;
        c_d     = c_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    sum_d   = sum_in;
                    carry_d = carry_in;
                    c_d     = cin;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d = res_step;
                c_d   = step_carry;
                idx_d = idx_q + IDX_W'(1);
                if (last_step) begin
                    cout_d  = step_carry;
                    state_d = DONE;
                end
`ifdef CSA_RESOLVE_EARLY_EXIT_EN
                else if (early) begin
                    res_d   = res_early;
                    cout_d  = 1'b0;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (ready_out) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign ready_in  = (state_q == IDLE);
    assign valid_out = (state_q == DONE);
    assign data_out  = res_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_vx_csa_resolve.sv
// Scoreboard bench for vx_csa_resolve: directed corner cases, reset abort, then random traffic with stalls.
module tb_vx_csa_resolve;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in, ready_in, cin, valid_out, cout;
    logic        ready_out = 1'b1;
    logic [31:0] sum_in, carry_in, data_out;

    logic        r30_valid_in, r30_ready_in, r30_cin, r30_valid_out, r30_cout;
    logic        r30_ready_out = 1'b1;
    logic [29:0] r30_sum, r30_carry, r30_data;

    int          total = 0;
    int          bad = 0;
    int          n_pushed = 0;
    int          n_popped = 0;
    logic [32:0] exp_q[$];
    bit          rand_rdy = 1'b0;
    bit          rdy_fixed = 1'b1;

`ifdef CSA_RESOLVE_EARLY_EXIT_EN
    localparam int LAT_036 = 1;
`else
    localparam int LAT_036 = 4;
`endif

    vx_csa_resolve #(.W(32), .CHUNK(8)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in),
        .sum_in(sum_in), .carry_in(carry_in), .cin(cin), .valid_out(valid_out),
        .ready_out(ready_out), .data_out(data_out), .cout(cout)
    );

    vx_csa_resolve #(.W(30), .CHUNK(8)) dut30 (
        .clk(clk), .reset_n(reset_n), .valid_in(r30_valid_in), .ready_in(r30_ready_in),
        .sum_in(r30_sum), .carry_in(r30_carry), .cin(r30_cin), .valid_out(r30_valid_out),
        .ready_out(r30_ready_out), .data_out(r30_data), .cout(r30_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] ref_add(input logic [31:0] s, input logic [31:0] c, input logic ci);
        return {1'b0, s} + {1'b0, c} + 33'(ci);
    endfunction

    // Call between edges; offers the pair until accepted and queues the expected result.
    task automatic send(input logic [31:0] s, input logic [31:0] c, input logic ci, output int waits);
        waits    = 0;
        sum_in   = s;
        carry_in = c;
        cin      = ci;
        valid_in = 1'b1;
        while (!ready_in && waits < 200) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!ready_in) begin
            check("accept_timeout", ready_in, 1);
            valid_in = 1'b0;
            return;
        end
        exp_q.push_back(ref_add(s, c, ci));
        n_pushed++;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sum_in   = $urandom;
        carry_in = $urandom;
        cin      = 1'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            seen = valid_out;
        end
        if (!seen) check("valid_timeout", valid_out, 1);
    endtask

    // ready_out driver
    initial begin
        forever begin
            @(posedge clk);
            #2;
            ready_out = rand_rdy ? ($urandom_range(0, 2) != 0) : rdy_fixed;
        end
    end

    // monitor / scoreboard
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", valid_out, 0);
                end else begin
                    e = exp_q.pop_front();
                    n_popped++;
                    check("result_data", data_out, e[31:0]);
                    check("result_cout", cout, e[32]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int          w, lat, guard;
        logic [31:0] s, c;
        logic [32:0] e;
        reset_n      = 1'b0;
        valid_in     = 1'b0;
        sum_in       = '0;
        carry_in     = '0;
        cin          = 1'b0;
        r30_valid_in = 1'b0;
        r30_sum      = '0;
        r30_carry    = '0;
        r30_cin      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_out", valid_out, 0);
        check("reset_ready_in", ready_in, 1);
        check("reset_data_out", data_out, 0);
        check("reset_cout", cout, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // full carry ripple; also first transfer right after reset release
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, w);
        check("first_accept_waits", w, 0);
        wait_valid(lat);
        check("lat_ripple", lat, 4);

        send(32'h1234_5678, 32'h0000_0001, 1'b1, w);
        wait_valid(lat);
        check("lat_short_carry", lat, LAT_036);

        // hold result under back-pressure
        rdy_fixed = 1'b0;
        @(posedge clk);
        #3;
        send(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, w);
        e = ref_add(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            check("stall_hold", {valid_out, ready_in, cout, data_out}, {1'b1, 1'b0, e});
            @(negedge clk);
        end
        rdy_fixed = 1'b1;
        @(posedge clk);
        #3;
        check("stall_release_still_done", valid_out, 1);
        @(posedge clk);
        #3;
        check("back_to_idle", {valid_out, ready_in}, {1'b0, 1'b1});

        // narrow width with a ragged last chunk
        r30_sum      = 30'h3FFF_FFFF;
        r30_carry    = 30'h0000_0001;
        r30_cin      = 1'b0;
        r30_valid_in = 1'b1;
        @(posedge clk);
        #3;
        r30_valid_in = 1'b0;
        lat = 0;
        while (!r30_valid_out && lat < 60) begin
            @(posedge clk);
            #3;
            lat++;
        end
        check("w30_latency", lat, 4);
        check("w30_data", r30_data, 0);
        check("w30_cout", r30_cout, 1);
        @(posedge clk);
        #3;

        // reset in the middle of a resolve
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, w);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        void'(exp_q.pop_back());
        n_pushed--;
        #1;
        check("abort_state", {valid_out, ready_in, cout, data_out}, {1'b1 ^ 1'b1, 1'b1, 33'h0});
        @(negedge clk);
        reset_n = 1'b1;
        send(32'h0000_0005, 32'h0000_0003, 1'b0, w);
        check("post_reset_accept_waits", w, 0);
        wait_valid(lat);
        check("post_reset_valid", valid_out, 1);

        // random traffic with random downstream stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s = $urandom;
            c = $urandom;
            case ($urandom_range(0, 3))
                0: c = c & 32'h0000_00FF;
                1: c = c & 32'h0000_FFFF;
                2: s = 32'hFFFF_FFFF;
                default: ;
            endcase
            send(s, c, 1'($urandom), w);
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check("drain_queue", exp_q.size(), 0);
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("results_count", n_popped, n_pushed);
        check("final_idle", {valid_out, ready_in}, {1'b0, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vx_csa_resolve.md
VX_CSA_RESOLVE -- requirements
Module: VX_csa_resolve

Interface
REQ-001 SHALL have parameter W, default 32: width of each redundant operand and of the result.
REQ-002 SHALL have parameter CHUNK, default 8: bits resolved per cycle, 1 <= CHUNK <= W.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port valid_in, input, 1: a redundant pair is offered.
REQ-006 SHALL have port ready_in, output, 1: the block accepts a pair.
REQ-007 SHALL have port sum_in, input, W: sum vector of the carry-save pair.
REQ-008 SHALL have port carry_in, input, W: carry vector, already aligned to the same weights as sum_in.
REQ-009 SHALL have port cin, input, 1: carry into bit 0.
REQ-010 SHALL have port valid_out, output, 1: the result is valid.
REQ-011 SHALL have port ready_out, input, 1: the downstream stage accepts the result.
REQ-012 SHALL have port data_out, output, W: binary result, (sum_in + carry_in + cin) mod 2^W.
REQ-013 SHALL have port cout, output, 1: carry out of bit W-1.

Function
REQ-014 SHALL resolve one accepted pair into binary form using a CHUNK-bit carry-propagate step per cycle; NSTEPS = ceil(W/CHUNK).
REQ-015 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-016 IDLE SHALL drive ready_in=1 and valid_out=0.
REQ-017 A transfer SHALL occur when valid_in and ready_in are both 1 on a rising edge of clk.
REQ-018 On a transfer the block SHALL latch sum_in, carry_in and cin, clear the chunk index to 0, and enter BUSY.
REQ-019 BUSY SHALL drive ready_in=0 and valid_out=0.
REQ-020 Each BUSY cycle SHALL add chunk idx of both vectors plus the running carry, write bits [idx*CHUNK +: CHUNK] of the result register, update the running carry, and increment idx.
REQ-021 The final chunk SHALL be W - (NSTEPS-1)*CHUNK bits wide; cout SHALL be the carry out of bit W-1, not out of the padded chunk.
REQ-022 After the final chunk the FSM SHALL enter DONE, so valid_out rises NSTEPS cycles after the accepting edge.
REQ-023 DONE SHALL drive valid_out=1 with ready_in=0.
REQ-024 In DONE, data_out and cout SHALL hold stable while ready_out=0.
REQ-025 In DONE, valid_out=1 with ready_out=1 SHALL return the FSM to IDLE on the next edge; a new pair SHALL NOT be accepted in that same cycle.
REQ-026 valid_in and input data changes while ready_in=0 SHALL have no effect.
REQ-027 When W == CHUNK (NSTEPS=1), BUSY SHALL last exactly one cycle.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately force the state to IDLE, clear idx, the running carry and the result register, and drive data_out=0, cout=0, valid_out=0, ready_in=1.
REQ-029 A reset during BUSY or DONE SHALL discard the pair in flight without producing a result.
REQ-030 After reset_n is released, the first transfer SHALL be possible on the first rising edge of clk.

Configuration
REQ-031 Macro CSA_RESOLVE_EARLY_EXIT_EN SHALL compile early exit in or out.
REQ-032 With CSA_RESOLVE_EARLY_EXIT_EN defined: when, after resolving chunk idx, the running carry is 0 and all carry-vector bits above that chunk are 0, the block SHALL copy the remaining sum bits into the result, set cout=0, and enter DONE on that edge. Latency is then 1..NSTEPS cycles.
REQ-033 With CSA_RESOLVE_EARLY_EXIT_EN undefined, latency SHALL always be exactly NSTEPS cycles.
REQ-034 Results SHALL be identical with and without the macro.

Verification (W=32, CHUNK=8 unless stated)
REQ-035 sum_in=0xFFFFFFFF, carry_in=0x00000001, cin=0 -> data_out=0x00000000, cout=1, valid_out 4 cycles after accept, in both builds.
REQ-036 sum_in=0x12345678, carry_in=0x00000001, cin=1 -> data_out=0x1234567A, cout=0; valid_out after 1 cycle with EARLY_EXIT, after 4 cycles without.
REQ-037 Completed result with ready_out held 0 for 10 cycles -> valid_out=1 and data_out stable throughout, ready_in=0 throughout; ready_out=1 -> IDLE on the next edge, ready_in=1.
REQ-038 W=30, CHUNK=8, sum_in=0x3FFFFFFF, carry_in=0x00000001 -> data_out=0, cout=1, latency 4 cycles.
REQ-039 reset_n pulsed low during BUSY cycle 2 -> valid_out=0, ready_in=1 immediately; the next pair 0x00000005 + 0x00000003 -> data_out=0x00000008.
REQ-040 Random back-to-back pairs with random ready_out stalls -> every result matches the modular reference sum, none lost or duplicated.
